// File: rtl/tiny_mem_pkg.sv
// Shared definitions for the TinyRAM memory-side blocks.
// Holds the arbiter state encoding and default RAM geometry.
package tiny_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int unsigned TINY_ADDR_W = 8;
    localparam int unsigned TINY_DATA_W = 8;

endpackage

// File: rtl/tiny_rr_pick.sv
// Combinational round-robin picker: searches req starting at last+1 (mod N_REQ)
// and returns the first set bit as a one-hot winner plus its index.
module tiny_rr_pick #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         winner,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic                    found;
    int unsigned             cand;
    logic [IDX_W-1:0]        cand_idx;

    always_comb begin
        winner   = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand     = (32'(last) + off) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found  = 1'b1;
                winner = N_REQ'(1) << cand;
                idx    = cand_idx;
            end
        end
    end

endmodule

// File: rtl/tiny_ram_arbiter.sv
// Round-robin arbiter sharing the single-port TinyRAM between N_REQ masters.
// Each transaction takes IDLE -> ACCESS (one RAM strobe cycle) -> RESP (ack).
module tiny_ram_arbiter
    import tiny_mem_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = TINY_ADDR_W,
    parameter int unsigned DATA_W = TINY_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          gnt,
    output logic                      ram_read,
    output logic                      ram_write,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_t         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;

    tiny_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick_onehot;
                    we_d    = we[pick_idx];
                    addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = wdata[pick_idx*DATA_W +: DATA_W];
                    last_d  = pick_idx;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = ram_rdata;
                end
                ack_d   = gnt_q;
                state_d = RESP;
            end
            RESP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
        end
    end

    // Strobes are gated by rst directly so a reset during ACCESS aborts the write.
    assign ram_read  = (state_q == ACCESS) && !we_q && !rst;
    assign ram_write = (state_q == ACCESS) &&  we_q && !rst;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ack       = ack_q;
    assign gnt       = gnt_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_tiny_ram_arbiter.sv
// Directed self-checking bench for tiny_ram_arbiter with a 256x8 RAM model.
module tb_tiny_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, ack, gnt;
    logic [7:0]  a0, a1, d0, d1;
    logic [15:0] addr, wdata;
    logic [7:0]  rdata, ram_addr, ram_wdata, ram_rdata;
    logic        ram_read, ram_write;
    logic [7:0]  mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    assign addr  = {a1, a0};
    assign wdata = {d1, d0};

    always #5 clk = ~clk;

    tiny_ram_arbiter #(
        .N_REQ  (2),
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .gnt       (gnt),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    assign ram_rdata = ram_read ? mem[ram_addr] : 8'h00;
    always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h20] = 8'h11;
        mem[8'h05] = 8'h5A;
        mem[8'h06] = 8'hC3;
        rst = 1'b1; req = '0; we = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        step(); step();
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_strobes", {ram_read, ram_write}, 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);

        // single read by master 0
        req = 2'b01; we = 2'b00; a0 = 8'h10;
        step();
        check("rd_gnt", 32'(gnt), 2'b01);
        check("rd_strobe", {ram_read, ram_write}, 2'b10);
        check("rd_addr", 32'(ram_addr), 8'h10);
        check("rd_ack_early", 32'(ack), 0);
        req = 2'b00;
        step();
        check("rd_ack", 32'(ack), 2'b01);
        check("rd_data", 32'(rdata), 8'hA5);
        check("rd_strobe_off", {ram_read, ram_write}, 0);
        step();
        check("rd_ack_done", 32'(ack), 0);
        check("rd_gnt_idle", 32'(gnt), 0);

        // master 1 writes 0x3C to 0xFF, master 0 reads it back
        req = 2'b10; we = 2'b10; a1 = 8'hFF; d1 = 8'h3C;
        step();
        check("wr_gnt", 32'(gnt), 2'b10);
        check("wr_strobe", {ram_read, ram_write}, 2'b01);
        check("wr_addr", 32'(ram_addr), 8'hFF);
        check("wr_wdata", 32'(ram_wdata), 8'h3C);
        req = 2'b00; we = 2'b00;
        step();
        check("wr_ack", 32'(ack), 2'b10);
        check("wr_mem", 32'(mem[8'hFF]), 8'h3C);
        check("wr_rdata_kept", 32'(rdata), 8'hA5);
        step();
        req = 2'b01; a0 = 8'hFF;
        step();
        check("rb_gnt", 32'(gnt), 2'b01);
        check("rb_strobe", {ram_read, ram_write}, 2'b10);
        req = 2'b00;
        step();
        check("rb_ack", 32'(ack), 2'b01);
        check("rb_data", 32'(rdata), 8'h3C);
        step();

        // contention after reset: grants alternate starting with master 0
        rst = 1'b1; step(); rst = 1'b0;
        req = 2'b11; we = 2'b00; a0 = 8'h10; a1 = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            step();
            check("ct_gnt", 32'(gnt), (k % 2 == 0) ? 2'b01 : 2'b10);
            check("ct_noack", 32'(ack), 0);
            step();
            check("ct_ack", 32'(ack), (k % 2 == 0) ? 2'b01 : 2'b10);
            check("ct_data", 32'(rdata), (k % 2 == 0) ? 8'hA5 : 8'h3C);
            check("ct_strobe_resp", {ram_read, ram_write}, 0);
            if (k == 5) req = 2'b00;
            step();
            check("ct_idle_ack", 32'(ack), 0);
            check("ct_idle_gnt", 32'(gnt), 0);
        end

        // master 0 holds req across its ack: one ack, no extra access
        req = 2'b01; a0 = 8'h10;
        step();
        check("hd_gnt", 32'(gnt), 2'b01);
        step();
        check("hd_ack", 32'(ack), 2'b01);
        step();
        check("hd_idle_ack", 32'(ack), 0);
        check("hd_idle_strobe", {ram_read, ram_write}, 0);
        req = 2'b00;
        step();
        check("hd_no_regrant", 32'(gnt), 0);
        check("hd_no_access", {ram_read, ram_write}, 0);
        check("hd_no_dup_ack", 32'(ack), 0);

        // reset during ACCESS of a write aborts it
        req = 2'b01; we = 2'b01; a0 = 8'h20; d0 = 8'h77;
        step();
        check("rw_strobe", {ram_read, ram_write}, 2'b01);
        rst = 1'b1;
        #1;
        check("rw_gated", {ram_read, ram_write}, 0);
        req = 2'b00; we = 2'b00;
        step();
        check("rw_mem_kept", 32'(mem[8'h20]), 8'h11);
        check("rw_ack", 32'(ack), 0);
        rst = 1'b0;
        step();
        check("rw_ack_after", 32'(ack), 0);
        req = 2'b11; a0 = 8'h10; a1 = 8'hFF;
        step();
        check("rw_first_gnt", 32'(gnt), 2'b01);
        req = 2'b00;
        step();
        check("rw_first_ack", 32'(ack), 2'b01);
        check("rw_first_data", 32'(rdata), 8'hA5);
        step();

        // input change during ACCESS does not affect transaction
        req = 2'b01; we = 2'b00; a0 = 8'h05;
        step();
        check("ic_addr", 32'(ram_addr), 8'h05);
        a0 = 8'h06; req = 2'b00;
        #1;
        check("ic_addr_held", 32'(ram_addr), 8'h05);
        step();
        check("ic_ack", 32'(ack), 2'b01);
        check("ic_data", 32'(rdata), 8'h5A);
        step();
        check("ic_addr_idle", 32'(ram_addr), 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
